// File: rtl/shift_pkg.sv
// Opcode encoding and helpers shared by the shift/rotate pipeline.
package shift_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_SLL = 3'b000;
  localparam op_t OP_SRL = 3'b001;
  localparam op_t OP_SRA = 3'b010;
  localparam op_t OP_ROL = 3'b011;
  localparam op_t OP_ROR = 3'b100;

  function automatic logic is_legal_op(op_t op);
    return op <= OP_ROR;
  endfunction

endpackage

// File: rtl/shift_unit_pipe_if.sv
// Operand/result handshake bundle between the source, the shift pipeline and the consumer.
interface shift_unit_pipe_if #(
  parameter int WIDTH = 8
);
  import shift_pkg::*;
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  op_t              in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;
  logic             out_illegal;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero, out_illegal
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero, out_illegal
  );
endinterface

// File: rtl/shift_core.sv
// Combinational log2(WIDTH)-level barrel shifter/rotator with carry, zero and illegal flags.
module shift_core
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             illegal
);

  logic [WIDTH-1:0] lvl [AMT_W+1];
  logic [AMT_W-1:0] sll_idx;
  logic [AMT_W-1:0] srl_idx;

  assign lvl[0] = data;

  // Level k moves by 2**k; the sign bit is untouched until the end, so SRA fill stays correct.
  for (genvar k = 0; k < AMT_W; k++) begin : g_lvl
    localparam int SH = 1 << k;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;

    assign cur = lvl[k];

    always_comb begin
      nxt = cur;
      if (amt[k]) begin
        case (op)
          OP_SLL:  nxt = {cur[WIDTH-SH-1:0], {SH{1'b0}}};
          OP_SRL:  nxt = {{SH{1'b0}}, cur[WIDTH-1:SH]};
          OP_SRA:  nxt = {{SH{cur[WIDTH-1]}}, cur[WIDTH-1:SH]};
          OP_ROL:  nxt = {cur[WIDTH-SH-1:0], cur[WIDTH-1:WIDTH-SH]};
          OP_ROR:  nxt = {cur[SH-1:0], cur[WIDTH-1:SH]};
          default: nxt = cur;
        endcase
      end
    end

    assign lvl[k+1] = nxt;
  end

  // WIDTH-n and n-1, both taken modulo WIDTH; only used when n != 0.
  assign sll_idx = ~amt + AMT_W'(1);
  assign srl_idx = amt - AMT_W'(1);

  always_comb begin
    carry = 1'b0;
    if (amt != '0) begin
      case (op)
        OP_SLL:         carry = data[sll_idx];
        OP_SRL, OP_SRA: carry = data[srl_idx];
        OP_ROL:         carry = lvl[AMT_W][0];
        OP_ROR:         carry = lvl[AMT_W][WIDTH-1];
        default:        carry = 1'b0;
      endcase
    end
  end

  assign illegal = !is_legal_op(op);
  assign result  = illegal ? data : lvl[AMT_W];
  assign zero    = (result == '0);

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage shift/rotate pipeline: stage 1 captures operands, stage 2 holds the result for the consumer.
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_unit_pipe_if.slave  bus
);

  logic             rdy_en;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [AMT_W-1:0] s1_amt;
  op_t              s1_op;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic             s2_carry;
  logic             s2_zero;
  logic             s2_illegal;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_zero;
  logic             core_illegal;

  logic s2_load;
  logic s1_adv;
  logic in_fire;

  shift_core #(.WIDTH(WIDTH)) u_core (
    .data    (s1_data),
    .amt     (s1_amt),
    .op      (s1_op),
    .result  (core_result),
    .carry   (core_carry),
    .zero    (core_zero),
    .illegal (core_illegal)
  );

  assign s2_load      = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_load;
  // rdy_en holds in_ready low until the first clock after reset release.
  assign bus.in_ready = rdy_en && (!s1_valid || s1_adv);
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en     <= 1'b0;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_amt     <= '0;
      s1_op      <= OP_SLL;
      s2_valid   <= 1'b0;
      s2_data    <= '0;
      s2_carry   <= 1'b0;
      s2_zero    <= 1'b0;
      s2_illegal <= 1'b0;
    end else begin
      rdy_en <= 1'b1;

      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_data  <= bus.in_data;
        s1_amt   <= bus.in_amt;
        s1_op    <= bus.in_op;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      // Result registers only change when a new beat lands, keeping out_* stable under stall.
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data    <= core_result;
          s2_carry   <= core_carry;
          s2_zero    <= core_zero;
          s2_illegal <= core_illegal;
        end
      end
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_data    = s2_data;
  assign bus.out_carry   = s2_carry;
  assign bus.out_zero    = s2_zero;
  assign bus.out_illegal = s2_illegal;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed and random checks of shift_unit_pipe against an arithmetic reference model.
module tb_shift_unit_pipe;
  import shift_pkg::*;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    logic         zero;
    logic         ill;
    int           stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   last_in_fire = 0;
  bit   lat_chk = 0;
  exp_t sb[$];
  logic [W-1:0] held;

  shift_unit_pipe_if #(.WIDTH(W)) bus ();

  shift_unit_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] d, input int n, input logic [2:0] op);
    exp_t e;
    logic [W-1:0] r;
    logic c;
    c = 1'b0;
    case (op)
      3'd0: begin r = d << n;                      if (n != 0) c = d[W-n]; end
      3'd1: begin r = d >> n;                      if (n != 0) c = d[n-1]; end
      3'd2: begin r = W'($signed(d) >>> n);        if (n != 0) c = d[n-1]; end
      3'd3: begin r = (d << n) | (d >> (W - n));   if (n != 0) c = r[0]; end
      3'd4: begin r = (d >> n) | (d << (W - n));   if (n != 0) c = r[W-1]; end
      default: r = d;
    endcase
    e.data  = r;
    e.carry = c;
    e.zero  = (r == 0);
    e.ill   = (op > 3'd4);
    e.stamp = 0;
    return e;
  endfunction

  // One clock: score any output and input transfers happening at the coming edge.
  task automatic tick();
    exp_t e;
    #1;
    last_in_fire = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 32'(bus.out_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.data));
        chk("out_carry", 32'(bus.out_carry), 32'(e.carry));
        chk("out_zero", 32'(bus.out_zero), 32'(e.zero));
        chk("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
        if (lat_chk) chk("latency", 32'(cyc - e.stamp), 2);
      end
    end
    if (last_in_fire) begin
      e = model(bus.in_data, int'(bus.in_amt), bus.in_op);
      e.stamp = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_beat(input logic [W-1:0] d, input logic [2:0] a, input logic [2:0] op);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_amt   = a;
    bus.in_op    = op;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    chk("drain_empty", 32'(sb.size()), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_amt    = '0;
    bus.in_op     = 3'd0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_flags", {29'd0, bus.out_carry, bus.out_zero, bus.out_illegal}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Directed vectors, free-flowing output
    bus.out_ready = 1'b1;
    set_beat(8'b1010_0000, 3'd2, 3'd2); tick();
    set_beat(8'b1010_0000, 3'd1, 3'd1); tick();
    set_beat(8'b1100_0011, 3'd2, 3'd0); tick();
    set_beat(8'b1000_0000, 3'd1, 3'd0); tick();
    set_beat(8'b1000_0001, 3'd3, 3'd3); tick();
    set_beat(8'b1000_0001, 3'd1, 3'd4); tick();
    for (int op = 0; op < 8; op++) begin
      set_beat(8'hC5, 3'd0, 3'(op)); tick();
    end
    set_beat(8'h5A, 3'd3, 3'd7); tick();
    set_beat(8'h00, 3'd4, 3'd6); tick();
    set_beat(8'h81, 3'd7, 3'd0); tick();
    set_beat(8'h81, 3'd7, 3'd2); tick();
    drain();

    // Backpressure: two beats fill the pipe, the third is refused
    bus.out_ready = 1'b0;
    set_beat(8'h11, 3'd1, 3'd0); tick();
    chk("stall_acc1", 32'(last_in_fire), 1);
    set_beat(8'h22, 3'd2, 3'd3); tick();
    chk("stall_acc2", 32'(last_in_fire), 1);
    set_beat(8'h33, 3'd3, 3'd4); tick();
    chk("stall_ready3", 32'(last_in_fire), 0);
    held = sb[0].data;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_out_valid", 32'(bus.out_valid), 1);
      chk("stall_out_hold", 32'(bus.out_data), 32'(held));
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && !last_in_fire; i++) tick();
    chk("stall_acc3", 32'(last_in_fire), 1);
    drain();

    // Streaming: no bubbles, fixed 2-cycle latency
    lat_chk = 1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_beat(W'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      tick();
      chk("stream_ready", 32'(last_in_fire), 1);
    end
    drain();
    lat_chk = 0;

    // Random valid/ready on both sides
    bus.in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.in_valid || last_in_fire) begin
        set_beat(W'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        bus.in_valid = ($urandom_range(0, 3) != 0);
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    set_beat(8'hF0, 3'd1, 3'd1); tick();
    set_beat(8'h0F, 3'd2, 3'd0); tick();
    bus.in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_out_data", 32'(bus.out_data), 0);
    chk("midrst_flags", {29'd0, bus.out_carry, bus.out_zero, bus.out_illegal}, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_quiet", 32'(bus.out_valid), 0);
    end
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
